// File: rtl/race_timer_pkg.sv
// Shared game-state encodings and race timer FSM types.
// Mirrors the state FSM's encoding so both sides agree on codes.
package race_timer_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETTING   = 3'd1;
    localparam logic [2:0] ST_COUNTDOWN = 3'd3;
    localparam logic [2:0] ST_RACING    = 3'd4;
    localparam logic [2:0] ST_PAUSE     = 3'd5;
    localparam logic [2:0] ST_FINISH    = 3'd6;

    localparam logic [15:0] NO_LAP = 16'hFFFF;

    typedef enum logic [1:0] {
        T_IDLE,
        T_RUN,
        T_HOLD,
        T_DONE
    } tstate_e;

endpackage

// File: rtl/race_timer_cs_tick_gen.sv
// Centisecond prescaler: counts 0..DIV-1 while enabled,
// emitting a one-cycle tick on wrap.
module cs_tick_gen #(
    parameter int unsigned DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = en & ~clr & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/race_timer.sv
// Race clock and lap tracker: elapsed/lap time, lap counting,
// best lap and end-of-race detection driven by the game state.
module race_timer
    import race_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned TICK_DIV      = CLK_HZ / 100,
    parameter int unsigned NUM_LAPS      = 3,
    parameter int unsigned TIME_LIMIT_CS = 60000,
    parameter int unsigned MIN_LAP_CS    = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state,
    input  logic        lap_cross,
    output logic [15:0] race_time_cs,
    output logic [15:0] lap_time_cs,
    output logic [15:0] last_lap_cs,
    output logic [15:0] best_lap_cs,
    output logic [2:0]  lap_cnt,
    output logic        lap_pulse,
    output logic        timeout,
    output logic        is_game_end
);
    tstate_e     t_q;
    logic        lc_q;
    logic [15:0] race_q, lap_q, last_q, best_q;
    logic [2:0]  cnt_q;
    logic        pulse_q, tmo_q, end_q;

    logic is_clr, run, tick, rise, accept, lap_fin, time_end;

    assign is_clr   = (state == ST_IDLE) || (state == ST_COUNTDOWN);
    assign run      = (t_q == T_RUN);
    assign rise     = lap_cross & ~lc_q;
    assign accept   = run & rise & (lap_q >= 16'(MIN_LAP_CS));
    assign lap_fin  = accept & ((cnt_q + 3'd1) == 3'(NUM_LAPS));
    assign time_end = tick & ((race_q + 16'd1) == 16'(TIME_LIMIT_CS));

    cs_tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (run),
        .clr (is_clr),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_q     <= T_IDLE;
            lc_q    <= 1'b0;
            race_q  <= '0;
            lap_q   <= '0;
            last_q  <= '0;
            best_q  <= NO_LAP;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            tmo_q   <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            lc_q    <= lap_cross;
            pulse_q <= 1'b0;
            if (is_clr) begin
                t_q    <= T_IDLE;
                race_q <= '0;
                lap_q  <= '0;
                last_q <= '0;
                best_q <= NO_LAP;
                cnt_q  <= '0;
                tmo_q  <= 1'b0;
                end_q  <= 1'b0;
            end else begin
                unique case (t_q)
                    T_IDLE: begin
                        if (state == ST_RACING) t_q <= T_RUN;
                    end
                    T_RUN: begin
                        if (tick) race_q <= race_q + 16'd1;
                        // A tick coinciding with a crossing counts toward the new lap
                        if (accept) begin
                            lap_q   <= {15'd0, tick};
                            cnt_q   <= cnt_q + 3'd1;
                            last_q  <= lap_q;
                            best_q  <= (lap_q < best_q) ? lap_q : best_q;
                            pulse_q <= 1'b1;
                        end else if (tick) begin
                            lap_q <= lap_q + 16'd1;
                        end
                        if (lap_fin) begin
                            t_q   <= T_DONE;
                            end_q <= 1'b1;
                            tmo_q <= 1'b0;
                        end else if (time_end) begin
                            t_q   <= T_DONE;
                            end_q <= 1'b1;
                            tmo_q <= 1'b1;
                        end else if (state == ST_PAUSE) begin
                            t_q <= T_HOLD;
                        end
                    end
                    T_HOLD: begin
                        if (state == ST_RACING) t_q <= T_RUN;
                    end
                    T_DONE: begin
                    end
                    default: t_q <= T_IDLE;
                endcase
            end
        end
    end

    assign race_time_cs = race_q;
    assign lap_time_cs  = lap_q;
    assign last_lap_cs  = last_q;
    assign best_lap_cs  = best_q;
    assign lap_cnt      = cnt_q;
    assign lap_pulse    = pulse_q;
    assign timeout      = tmo_q;
    assign is_game_end  = end_q;

endmodule

// File: tb/tb_race_timer.sv
// Scoreboard bench for race_timer: two instances share stimulus,
// one with a 40 cs limit and one with a 20 cs limit.
module tb_race_timer;
    import race_timer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] state = ST_IDLE;
    logic       lap_cross = 1'b0;

    logic [15:0] rt1, lt1, ll1, bl1, rt2, lt2, ll2, bl2;
    logic [2:0]  lc1, lc2;
    logic        lp1, to1, ge1, lp2, to2, ge2;

    int n_vec = 0;
    int n_err = 0;
    int np1 = 0;
    int np2 = 0;

    always #5 clk = ~clk;

    race_timer #(
        .CLK_HZ(400), .TICK_DIV(4), .NUM_LAPS(3),
        .TIME_LIMIT_CS(40), .MIN_LAP_CS(8)
    ) dut (
        .clk(clk), .rst(rst), .state(state), .lap_cross(lap_cross),
        .race_time_cs(rt1), .lap_time_cs(lt1), .last_lap_cs(ll1),
        .best_lap_cs(bl1), .lap_cnt(lc1), .lap_pulse(lp1),
        .timeout(to1), .is_game_end(ge1)
    );

    // Short-limit instance; a lower minimum lap lets 3 laps fit in 20 cs
    race_timer #(
        .CLK_HZ(400), .TICK_DIV(4), .NUM_LAPS(3),
        .TIME_LIMIT_CS(20), .MIN_LAP_CS(4)
    ) dut2 (
        .clk(clk), .rst(rst), .state(state), .lap_cross(lap_cross),
        .race_time_cs(rt2), .lap_time_cs(lt2), .last_lap_cs(ll2),
        .best_lap_cs(bl2), .lap_cnt(lc2), .lap_pulse(lp2),
        .timeout(to2), .is_game_end(ge2)
    );

    always @(negedge clk) begin
        if (lp1) np1 <= np1 + 1;
        if (lp2) np2 <= np2 + 1;
    end

    typedef struct {
        string       tag;
        logic [15:0] v;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic pop(input logic [15:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, got, e.v);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rise();
        lap_cross = 1'b1;
        step(1);
        lap_cross = 1'b0;
    endtask

    task automatic wait_lap(input bit s, input logic [15:0] tgt);
        int k;
        k = 0;
        while ((s ? lt2 : lt1) != tgt && k < 400) begin
            step(1);
            k++;
        end
        if (k == 400) chk("wait_lap", s ? lt2 : lt1, tgt);
    endtask

    task automatic expect_clear(input bit s);
        push("clr_race", 16'd0);
        push("clr_lap", 16'd0);
        push("clr_last", 16'd0);
        push("clr_best", NO_LAP);
        push("clr_cnt", 16'd0);
        push("clr_tmo", 16'd0);
        push("clr_end", 16'd0);
        pop(s ? rt2 : rt1);
        pop(s ? lt2 : lt1);
        pop(s ? ll2 : ll1);
        pop(s ? bl2 : bl1);
        pop(16'(s ? lc2 : lc1));
        pop(16'(s ? to2 : to1));
        pop(16'(s ? ge2 : ge1));
    endtask

    initial begin
        logic [15:0] r;
        int          k;
        int          n0;

        step(2);
        expect_clear(0);
        rst = 1'b1;
        step(1);

        // 41 clocks of racing after T_RUN entry
        state = ST_RACING;
        step(1);
        push("run41_race", 16'd10);
        push("run41_lap", 16'd10);
        step(41);
        pop(rt1);
        pop(lt1);

        // pause with prescaler frozen at 2, lap_cross held through it
        r = rt1;
        k = 0;
        while (rt1 == r && k < 10) begin
            step(1);
            k++;
        end
        if (k == 10) chk("tick_seen", rt1, r + 16'd1);
        step(1);
        state = ST_PAUSE;
        step(1);
        r = rt1;
        n0 = np1;
        lap_cross = 1'b1;
        push("hold_race", r);
        step(100);
        pop(rt1);
        chk("hold_pulse", 16'(np1 - n0), 16'd0);
        state = ST_RACING;
        push("resume1_race", r);
        push("resume2_race", r + 16'd1);
        step(2);
        pop(rt1);
        step(1);
        pop(rt1);
        step(10);
        chk("resume_pulse", 16'(np1 - n0), 16'd0);
        chk("resume_cnt", 16'(lc1), 16'd0);
        lap_cross = 1'b0;

        // lap sequence 5 (rejected), 12, 9, 15
        state = ST_COUNTDOWN;
        step(2);
        state = ST_RACING;
        step(1);
        n0 = np1;
        wait_lap(0, 16'd5);
        rise();
        chk("rej_pulse", 16'(lp1), 16'd0);
        chk("rej_cnt", 16'(lc1), 16'd0);
        wait_lap(0, 16'd12);
        rise();
        push("l1_pulse", 16'd1);
        push("l1_cnt", 16'd1);
        push("l1_last", 16'd12);
        push("l1_lap", 16'd0);
        pop(16'(lp1));
        pop(16'(lc1));
        pop(ll1);
        pop(lt1);
        wait_lap(0, 16'd9);
        rise();
        push("l2_best", 16'd9);
        push("l2_cnt", 16'd2);
        pop(bl1);
        pop(16'(lc1));
        wait_lap(0, 16'd15);
        lap_cross = 1'b1;
        chk("l3_end_early", 16'(ge1), 16'd0);
        step(1);
        lap_cross = 1'b0;
        push("l3_cnt", 16'd3);
        push("l3_last", 16'd15);
        push("l3_best", 16'd9);
        push("l3_end", 16'd1);
        push("l3_tmo", 16'd0);
        pop(16'(lc1));
        pop(ll1);
        pop(bl1);
        pop(16'(ge1));
        pop(16'(to1));
        step(1);
        chk("pulse_total", 16'(np1 - n0), 16'd3);
        chk("pulse_width", 16'(lp1), 16'd0);

        // asynchronous reset between clock edges
        #2;
        rst = 1'b0;
        #1;
        expect_clear(0);
        step(1);
        rst = 1'b1;

        // run to the 40 cs time limit
        k = 0;
        while (!ge1 && k < 300) begin
            step(1);
            k++;
        end
        push("lim_race", 16'd40);
        push("lim_lap", 16'd40);
        push("lim_tmo", 16'd1);
        push("lim_end", 16'd1);
        pop(rt1);
        pop(lt1);
        pop(16'(to1));
        pop(16'(ge1));

        // FINISH holds, IDLE clears, COUNTDOWN->RACING restarts
        state = ST_FINISH;
        step(5);
        push("fin_end", 16'd1);
        push("fin_race", 16'd40);
        pop(16'(ge1));
        pop(rt1);
        state = ST_IDLE;
        step(1);
        expect_clear(0);
        state = ST_COUNTDOWN;
        step(3);
        state = ST_RACING;
        step(1);
        step(3);
        chk("restart_race0", rt1, 16'd0);
        step(1);
        chk("restart_race1", rt1, 16'd1);

        // 20 cs limit, no crossings
        state = ST_IDLE;
        step(1);
        expect_clear(1);
        state = ST_RACING;
        step(1);
        step(79);
        chk("lim20_pre", rt2, 16'd19);
        chk("lim20_pre_end", 16'(ge2), 16'd0);
        step(1);
        push("lim20_race", 16'd20);
        push("lim20_tmo", 16'd1);
        push("lim20_end", 16'd1);
        pop(rt2);
        pop(16'(to2));
        pop(16'(ge2));
        step(20);
        chk("lim20_hold_race", rt2, 16'd20);
        chk("lim20_hold_lap", lt2, 16'd20);

        // third lap lands on the limit tick
        state = ST_IDLE;
        step(1);
        state = ST_RACING;
        step(1);
        wait_lap(1, 16'd6);
        rise();
        wait_lap(1, 16'd6);
        rise();
        chk("tie_cnt2", 16'(lc2), 16'd2);
        k = 0;
        while (rt2 != 16'd19 && k < 100) begin
            step(1);
            k++;
        end
        if (k == 100) chk("tie_wait", rt2, 16'd19);
        step(3);
        lap_cross = 1'b1;
        step(1);
        lap_cross = 1'b0;
        push("tie_race", 16'd20);
        push("tie_cnt", 16'd3);
        push("tie_tmo", 16'd0);
        push("tie_end", 16'd1);
        push("tie_lap", 16'd1);
        push("tie_last", 16'd7);
        pop(rt2);
        pop(16'(lc2));
        pop(16'(to2));
        pop(16'(ge2));
        pop(lt2);
        pop(ll2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
